// File: rtl/key_reader.sv
// key_reader: two-key debouncer producing a pressed level, press/release pulses and an up/down counter.
// Define KEY_READER_AUTOREPEAT_EN for autorepeat. `repeat` and `release` are SystemVerilog keywords,
// so the autorepeat period is the parameter repeat_period and the release pulses are the port key_release.
module key_reader #(
  parameter int unsigned width         = 8,
  parameter int unsigned debounce      = 50000,
  parameter int unsigned repeat_period = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       keys_n,
  output logic [1:0]       state,
  output logic [1:0]       press,
  output logic [1:0]       key_release,
  output logic [width-1:0] value
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_st_t;

  localparam logic [23:0] DEB_LAST = 24'(debounce - 1);

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       state_s, press_s, release_s;
  logic [width-1:0] value_q, value_d;

  // Inverting two-flop synchronizer: a held (low) key reads as 1 after two edges.
  always_comb begin
    sync1_d = ~keys_n;
    sync2_d = sync1_q;
  end

  // Synchronizer flops; reset to the released reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_st_t     st_q, st_d;
    logic [23:0] cnt_q, cnt_d;
    logic        lvl_q, lvl_d;
    logic        prs_q, prs_d;
    logic        rls_q, rls_d;
    logic        sync_s;
`ifdef KEY_READER_AUTOREPEAT_EN
    localparam logic [31:0] RPT_LAST = 32'(repeat_period - 1);
    logic [31:0] rpt_q, rpt_d;
`endif

    assign sync_s = sync2_q[i];

    // Per-key debounce FSM: a change is accepted only after debounce stable cycles.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rls_d = 1'b0;
`ifdef KEY_READER_AUTOREPEAT_EN
      rpt_d = rpt_q;
`endif
      case (st_q)
        RELEASED: begin
          if (sync_s) begin
            st_d  = PRESS_WAIT;
            cnt_d = 24'd0;
          end else begin
            st_d  = RELEASED;
          end
        end
        PRESS_WAIT: begin
          if (!sync_s) begin
            st_d = RELEASED;
          end else if (cnt_q == DEB_LAST) begin
            st_d  = PRESSED;
            lvl_d = 1'b1;
            prs_d = 1'b1;
`ifdef KEY_READER_AUTOREPEAT_EN
            rpt_d = 32'd0;
`endif
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        PRESSED: begin
          if (!sync_s) begin
            st_d  = RELEASE_WAIT;
            cnt_d = 24'd0;
          end else begin
            st_d  = PRESSED;
`ifdef KEY_READER_AUTOREPEAT_EN
            // Repeat count holds while bouncing through RELEASE_WAIT and resumes on return.
            if (rpt_q == RPT_LAST) begin
              prs_d = 1'b1;
              rpt_d = 32'd0;
            end else begin
              rpt_d = rpt_q + 32'd1;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (sync_s) begin
            st_d = PRESSED;
          end else if (cnt_q == DEB_LAST) begin
            st_d  = RELEASED;
            lvl_d = 1'b0;
            rls_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: begin
          st_d  = RELEASED;
          cnt_d = 24'd0;
          lvl_d = 1'b0;
        end
      endcase
    end

    // Per-key FSM state, stability counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= RELEASED;
        cnt_q <= 24'd0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rls_q <= 1'b0;
`ifdef KEY_READER_AUTOREPEAT_EN
        rpt_q <= 32'd0;
`endif
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rls_q <= rls_d;
`ifdef KEY_READER_AUTOREPEAT_EN
        rpt_q <= rpt_d;
`endif
      end
    end

    assign state_s[i]   = lvl_q;
    assign press_s[i]   = prs_q;
    assign release_s[i] = rls_q;
  end

  // Counter follows the registered press pulses; opposite presses in one cycle cancel.
  always_comb begin
    value_d = value_q;
    case (press_s)
      2'b01:   value_d = value_q + {{(width-1){1'b0}}, 1'b1};
      2'b10:   value_d = value_q - {{(width-1){1'b0}}, 1'b1};
      default: value_d = value_q;
    endcase
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign state       = state_s;
  assign press       = press_s;
  assign key_release = release_s;
  assign value       = value_q;

endmodule
